// File: rtl/ram_rd_arb_init.sv
// Init sequencer, round-robin read arbiter and response tagger in front of a 1R1W RAM.
// States:  S_INIT | fill every entry with INIT_VAL, all requesters stalled
//          S_RUN  | RAM initialized; one read and one write per cycle
module ram_rd_arb_init #(
    parameter int               DEPTH    = 4,
    parameter int               WIDTH    = 32,
    parameter int               RD_LAT   = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter int               ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    output logic             init_done,
    input  logic             rd0_valid,
    input  logic [DEPTH-1:0] rd0_addr,
    output logic             rd0_ready,
    input  logic             rd1_valid,
    input  logic [DEPTH-1:0] rd1_addr,
    output logic             rd1_ready,
    input  logic             wr_valid,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_perr,
    output logic             ram_we,
    output logic [DEPTH-1:0] ram_waddr,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_re,
    output logic [DEPTH-1:0] ram_raddr,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic             ram_perr,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [DEPTH-1:0]  icnt;
    logic              last_gnt;
    logic              run;
    logic              gnt0;
    logic              gnt1;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_id;

    assign run = (state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            icnt      <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    icnt <= icnt + 1'b1;
                    if (icnt == '1) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (init_req) begin
                        state     <= S_INIT;
                        icnt      <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_INIT;
                    icnt      <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // last_gnt names the requester served most recently; the other one wins a tie.
    assign gnt0 = run & rd0_valid & (~rd1_valid | last_gnt);
    assign gnt1 = run & rd1_valid & (~rd0_valid | ~last_gnt);

    assign rd0_ready = gnt0;
    assign rd1_ready = gnt1;
    assign ram_re    = gnt0 | gnt1;
    assign ram_raddr = gnt1 ? rd1_addr : rd0_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt0 | gnt1) begin
            last_gnt <= gnt1;
        end
    end

    assign wr_ready  = run;
    assign ram_we    = run ? wr_valid : 1'b1;
    assign ram_waddr = run ? wr_addr  : icnt;
    assign ram_din   = run ? wr_data  : INIT_VAL;

    // Tag pipeline runs independently of the FSM so reads issued before a re-init still return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= ram_re;
            pipe_id[0] <= gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign rsp_valid = pipe_v[RD_LAT-1];
    assign rsp_id    = pipe_id[RD_LAT-1];
    assign rsp_data  = ram_dout;
    assign rsp_perr  = ram_perr & rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= ERR_W'(rsp_perr);
        end else if (rsp_perr && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_rd_arb_init.sv
// Bench for ram_rd_arb_init: behavioural RAM, arbitration model and a response scoreboard.
module tb_ram_rd_arb_init;
    localparam int               DEPTH  = 4;
    localparam int               WIDTH  = 32;
    localparam int               RD_LAT = 1;
    localparam int               N      = 1 << DEPTH;
    localparam logic [WIDTH-1:0] INIT_V = 32'hC0DE_0001;

    logic             clk = 0, rst = 0, init_req = 0, err_clr = 0;
    logic             rd0_valid = 0, rd1_valid = 0, wr_valid = 0;
    logic [DEPTH-1:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             init_done, rd0_ready, rd1_ready, wr_ready;
    logic             rsp_valid, rsp_id, rsp_perr;
    logic [WIDTH-1:0] rsp_data, ram_din, ram_dout;
    logic             ram_we, ram_re, ram_perr;
    logic [DEPTH-1:0] ram_waddr, ram_raddr;
    logic [15:0]      err_cnt;

    logic             init_done2, rd0_ready2, rd1_ready2, wr_ready2;
    logic             rsp_valid2, rsp_id2, rsp_perr2, ram_we2, ram_re2;
    logic [WIDTH-1:0] rsp_data2, ram_din2;
    logic [DEPTH-1:0] ram_waddr2, ram_raddr2;
    logic [1:0]       err_cnt2;

    always #5 clk = ~clk;

    ram_rd_arb_init #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(RD_LAT), .INIT_VAL(INIT_V), .ERR_W(16)) u_dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done),
        .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
        .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_perr(rsp_perr),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_re(ram_re), .ram_raddr(ram_raddr),
        .ram_dout(ram_dout), .ram_perr(ram_perr), .err_clr(err_clr), .err_cnt(err_cnt));

    // Narrow-counter twin, fed identically, for saturation.
    ram_rd_arb_init #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(RD_LAT), .INIT_VAL(INIT_V), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done2),
        .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready2),
        .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready2),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready2),
        .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_data(rsp_data2), .rsp_perr(rsp_perr2),
        .ram_we(ram_we2), .ram_waddr(ram_waddr2), .ram_din(ram_din2), .ram_re(ram_re2), .ram_raddr(ram_raddr2),
        .ram_dout(ram_dout), .ram_perr(ram_perr), .err_clr(err_clr), .err_cnt(err_cnt2));

    logic [WIDTH-1:0] mem [N];
    logic [WIDTH-1:0] dq [RD_LAT];
    logic             perr_on = 0;

    always @(posedge clk) begin
        dq[0] <= mem[ram_raddr];
        for (int i = 1; i < RD_LAT; i++) dq[i] <= dq[i-1];
        if (ram_we) mem[ram_waddr] <= ram_din;
    end
    assign ram_dout = dq[RD_LAT-1];
    assign ram_perr = perr_on;

    typedef struct {
        int               due;
        logic             id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0, errors = 0, cyc = 0;
    logic [WIDTH-1:0] exp_mem [N];
    logic             exp_last = 1'b1;
    logic [15:0]      exp_err = '0;
    logic [1:0]       exp_err2 = '0;
    bit               mon_en = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        logic exp_v, exp_p;
        if (mon_en) begin
            if (rst) begin
                sb.delete();
                exp_err  = '0;
                exp_err2 = '0;
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    checks++; errors++;
                    $display("FAIL rsp_missing: due cycle %0d id %0d never returned", e.due, e.id);
                end
                exp_v = (sb.size() > 0) && (sb[0].due == cyc);
                checks++;
                if (rsp_valid !== exp_v) begin
                    errors++;
                    $display("FAIL rsp_valid: got %b expected %b at cycle %0d", rsp_valid, exp_v, cyc);
                end
                if (exp_v) begin
                    e = sb.pop_front();
                    checks++;
                    if (rsp_id !== e.id || rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL rsp_payload: got id %0d data %h expected id %0d data %h", rsp_id, rsp_data, e.id, e.data);
                    end
                end
                exp_p = exp_v & perr_on;
                checks++;
                if (rsp_perr !== exp_p || err_cnt !== exp_err || err_cnt2 !== exp_err2) begin
                    errors++;
                    $display("FAIL err_path: perr %b cnt %0d cnt2 %0d expected perr %b cnt %0d cnt2 %0d",
                             rsp_perr, err_cnt, err_cnt2, exp_p, exp_err, exp_err2);
                end
                if (err_clr) begin
                    exp_err  = exp_p ? 16'd1 : 16'd0;
                    exp_err2 = exp_p ? 2'd1 : 2'd0;
                end else if (exp_p) begin
                    if (exp_err != 16'hFFFF) exp_err++;
                    if (exp_err2 != 2'b11) exp_err2++;
                end
            end
        end
    end

    // One RUN-state cycle: drive, check the ports against the arbitration model, queue the response.
    task automatic drive_cycle(input logic v0, input logic [DEPTH-1:0] a0, input logic v1, input logic [DEPTH-1:0] a1,
                               input logic wv, input logic [DEPTH-1:0] wa, input logic [WIDTH-1:0] wd);
        logic g0, g1;
        rd0_valid = v0; rd0_addr = a0; rd1_valid = v1; rd1_addr = a1;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        g0 = v0 & (~v1 | exp_last);
        g1 = v1 & (~v0 | ~exp_last);
        checks++;
        if (rd0_ready !== g0 || rd1_ready !== g1) begin
            errors++;
            $display("FAIL grant: ready0 %b ready1 %b expected %b %b", rd0_ready, rd1_ready, g0, g1);
        end
        checks++;
        if (ram_re !== (g0 | g1) || ((g0 | g1) && ram_raddr !== (g1 ? a1 : a0))) begin
            errors++;
            $display("FAIL rd_port: re %b raddr %0d expected re %b raddr %0d", ram_re, ram_raddr, g0 | g1, g1 ? a1 : a0);
        end
        checks++;
        if (wr_ready !== 1'b1 || ram_we !== wv || (wv && (ram_waddr !== wa || ram_din !== wd))) begin
            errors++;
            $display("FAIL wr_port: ready %b we %b waddr %0d din %h expected 1 %b %0d %h", wr_ready, ram_we, ram_waddr, ram_din, wv, wa, wd);
        end
        if (g0 | g1) begin
            sb.push_back('{due: cyc + RD_LAT, id: g1, data: exp_mem[g1 ? a1 : a0]});
            exp_last = g1;
        end
        if (wv) exp_mem[wa] = wd;
        @(posedge clk); #1;
        rd0_valid = 0; rd1_valid = 0; wr_valid = 0;
    endtask

    // Entered one step after the edge that puts the block in INIT with icnt = 0.
    task automatic wait_init(input bit poke);
        rd0_valid = 1; rd0_addr = 4'd1; rd1_valid = 1; rd1_addr = 4'd2;
        wr_valid = 1; wr_addr = 4'd9; wr_data = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            if (poke && i == 8) init_req = 1;
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b1 || ram_waddr !== DEPTH'(i) || ram_din !== INIT_V) begin
                errors++;
                $display("FAIL init_wr: we %b addr %0d din %h expected 1 %0d %h", ram_we, ram_waddr, ram_din, i, INIT_V);
            end
            checks++;
            if (init_done !== 1'b0 || rd0_ready !== 1'b0 || rd1_ready !== 1'b0 || wr_ready !== 1'b0 || ram_re !== 1'b0) begin
                errors++;
                $display("FAIL init_block: done %b r0 %b r1 %b w %b re %b expected all 0", init_done, rd0_ready, rd1_ready, wr_ready, ram_re);
            end
            @(posedge clk); #1;
            init_req = 0;
        end
        rd0_valid = 0; rd1_valid = 0; wr_valid = 0;
        for (int i = 0; i < N; i++) exp_mem[i] = INIT_V;
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got %b expected 1", init_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2 rst = 1;
        mon_en = 1;
        rd0_valid = 1; rd1_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (init_done !== 0 || rsp_valid !== 0 || rsp_id !== 0 || rsp_perr !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL reset_out: done %b rv %b id %b perr %b cnt %0d expected all 0", init_done, rsp_valid, rsp_id, rsp_perr, err_cnt);
        end
        checks++;
        if (rd0_ready !== 0 || rd1_ready !== 0 || wr_ready !== 0 || ram_re !== 0) begin
            errors++;
            $display("FAIL reset_ready: r0 %b r1 %b w %b re %b expected 0", rd0_ready, rd1_ready, wr_ready, ram_re);
        end
        exp_last = 1'b1;
        rst = 0;
        wait_init(0);
    endtask

    task automatic test_arb;
        logic v0, v1, wv;
        logic [DEPTH-1:0] a0, a1, wa;
        for (int k = 0; k < 6; k++) drive_cycle(1, 4'd3, 1, 4'd5, 0, '0, '0);
        for (int k = 0; k < 30; k++) begin
            v0 = 1'($urandom_range(1)); v1 = 1'($urandom_range(1)); wv = 1'($urandom_range(1));
            a0 = DEPTH'($urandom_range(N - 1)); a1 = DEPTH'($urandom_range(N - 1)); wa = DEPTH'($urandom_range(N - 1));
            if ((v0 && wa == a0) || (v1 && wa == a1)) wv = 0;
            drive_cycle(v0, a0, v1, a1, wv, wa, $urandom);
        end
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
    endtask

    task automatic test_wr_rd;
        drive_cycle(0, '0, 0, '0, 1, 4'd7, 32'hA5A5_A5A5);
        drive_cycle(0, '0, 1, 4'd7, 0, '0, '0);
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
    endtask

    task automatic test_err;
        perr_on = 1;
        for (int k = 0; k < 4; k++) drive_cycle(1, DEPTH'(k), 0, '0, 0, '0, '0);
        err_clr = 1;
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
        err_clr = 0;
        checks++;
        if (err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL err_clr_hit: got %0d expected 1", err_cnt);
        end
        err_clr = 1;
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
        err_clr = 0;
        checks++;
        if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL err_clr_only: got %0d %0d expected 0 0", err_cnt, err_cnt2);
        end
        for (int k = 0; k < 5; k++) drive_cycle(0, '0, 1, DEPTH'(k + 8), 0, '0, '0);
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
        checks++;
        if (err_cnt !== 16'd5 || err_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL err_sat: got %0d %0d expected 5 3", err_cnt, err_cnt2);
        end
        perr_on = 0;
    endtask

    task automatic test_init_req;
        init_req = 1;
        drive_cycle(1, 4'd7, 0, '0, 0, '0, '0);
        init_req = 0;
        wait_init(1);
        drive_cycle(0, '0, 1, 4'd7, 0, '0, '0);
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
    endtask

    task automatic test_rst_mid;
        drive_cycle(0, '0, 0, '0, 1, 4'd4, 32'h1234_5678);
        drive_cycle(1, 4'd2, 0, '0, 0, '0, '0);
        drive_cycle(0, '0, 1, 4'd4, 0, '0, '0);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: rsp_valid %b expected 1", rsp_valid);
        end
        rst = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: rsp_valid %b init_done %b expected 0 0", rsp_valid, init_done);
        end
        exp_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        wait_init(0);
        drive_cycle(1, 4'd4, 1, 4'd6, 0, '0, '0);
        drive_cycle(0, '0, 0, '0, 0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_arb();
        test_wr_rd();
        test_err();
        test_init_req();
        test_rst_mid();
        repeat (RD_LAT + 1) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses outstanding expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_rd_arb_init.md
# ram_rd_arb_init

Controller in front of one `ram_1r1w` instance. After reset it zero-fills (or fills with `INIT_VAL`) every RAM entry, then arbitrates the single read port between two requesters round-robin. It passes one writer through to the write port and returns tagged, in-order read responses with the RAM parity error attached. It also keeps a saturating parity-error counter; a re-init can be requested at run time.

## Interface
- `DEPTH`, 4, RAM address width; the RAM holds 2^DEPTH entries.
- `WIDTH`, 32, data width.
- `RD_LAT`, 1, RAM read latency in cycles. Legal values: 1 (GRAM_MODE 1/2) or 2 (GRAM_MODE 3). The RAM is built with PIPELINE_PERR=0.
- `INIT_VAL`, '0, value written to every entry during init.
- `ERR_W`, 16, width of the error counter.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `init_req`  in  1  pulse; restarts the init sequence
- `init_done`  out  1  high when the RAM is initialized and the block accepts traffic
- `rd0_valid` / `rd1_valid`  in  1  read request
- `rd0_addr` / `rd1_addr`  in  DEPTH  read address
- `rd0_ready` / `rd1_ready`  out  1  request accepted this cycle
- `wr_valid`  in  1  write request
- `wr_addr`  in  DEPTH  write address
- `wr_data`  in  WIDTH  write data
- `wr_ready`  out  1  write accepted
- `rsp_valid`  out  1  read data valid
- `rsp_id`  out  1  requester index of the response
- `rsp_data`  out  WIDTH  read data
- `rsp_perr`  out  1  parity error on this response
- `ram_we`, `ram_waddr`, `ram_din`, `ram_re`, `ram_raddr`  out  RAM write/read controls
- `ram_dout`  in  WIDTH  RAM read data
- `ram_perr`  in  1  RAM parity error
- `err_clr`  in  1  clear the error counter
- `err_cnt`  out  ERR_W  saturating count of responses with `rsp_perr`

## Operation

**States**
- INIT:
  - Write `INIT_VAL` to address `icnt` every cycle, with `icnt` running 0 to 2^DEPTH-1.
  - `wr_ready`, `rd0_ready` and `rd1_ready` are all 0.
  - When `icnt` reaches 2^DEPTH-1, go to RUN.
- RUN:
  - `init_done` = 1.
  - `init_req` returns the block to INIT with `icnt` = 0.

**Write path**
- In RUN, `wr_ready` = 1.
- `ram_we` = `wr_valid & wr_ready`, with `ram_waddr`/`ram_din` taken from `wr_addr`/`wr_data`.
- In INIT, `ram_we` = 1 and `ram_waddr` = `icnt`.

**Read arbitration**
- In RUN, grant one valid requester per cycle; ready is combinational from valid.
- When both are valid, grant the requester not granted last. The last-grant pointer resets to 1, so rd0 wins the first conflict.
- The pointer updates only on a grant.
- `ram_re` = grant; `ram_raddr` = the granted address.

**Response path**
- A shift register RD_LAT deep carries (valid, id).
- `rsp_valid`/`rsp_id` come from the last stage; `rsp_data` = `ram_dout`; `rsp_perr` = `ram_perr & rsp_valid`.
- Reads granted before an `init_req` still complete normally.

**Error counter**
- Increments on `rsp_perr` and saturates at all-ones.
- `err_clr` has priority over the stored value: clear and error in the same cycle gives 1; clear alone gives 0.

**Same-address access**
- A simultaneous read and write to the same address is not forwarded. The data returned is whatever the RAM mode defines.

## Timing
- Reset values:
  - State INIT, `icnt` = 0, last-grant pointer = 1.
  - `init_done` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_perr` 0, `err_cnt` 0.
  - All ready outputs 0, `ram_re` 0.
  - `ram_we` is 1 from the first cycle after reset deasserts (INIT write of address 0).
- Init takes exactly 2^DEPTH cycles. `init_done` rises in the cycle after the final init write.
- Read latency: `rsp_valid` asserts exactly RD_LAT cycles after the grant cycle.
- Throughput: one read and one write per cycle in RUN.
- `init_req` in RUN: the next cycle is INIT, with `init_done` = 0 and a write to address 0. `init_req` during INIT is ignored.
- Reset asserted mid-operation: all state returns to reset values asynchronously and in-flight responses are dropped.

## Test plan
- Reset, DEPTH=4: `ram_we`=1 for 16 cycles with addresses 0..15 and data `INIT_VAL`; `init_done` rises on cycle 17; reading any address returns `INIT_VAL`.
- rd0 and rd1 held valid for 6 cycles, addresses 3 and 5: grants go 0,1,0,1,0,1; responses arrive RD_LAT later with ids 0,1,0,… and data mem[3]/mem[5].
- Write 0xA5A5A5A5 to address 7, read address 7 the next cycle from rd1: `rsp_data`=0xA5A5A5A5, `rsp_id`=1.
- Force `ram_perr` on 3 responses, then pulse `err_clr` together with a fourth error: `err_cnt` goes 1,2,3, then 1. With ERR_W=2 and 5 errors, `err_cnt` holds at 3.
- Pulse `init_req` in the same cycle as a granted read: the response still returns RD_LAT later; ready drops for 16 cycles and `init_done` returns high afterwards.
- Assert `rst` mid-burst with 2 reads in flight: `rsp_valid` is 0 immediately and no stale response appears after `rst` deasserts.
